// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect sequencer.
package sfx_pkg;

    // Sequencer state: one effect plays at a time.
    typedef enum logic [1:0] {
        StIdle,
        StShot,
        StHit
    } sfx_state_e;

    // Effect identifiers presented on sfx_id.
    localparam logic [1:0] SFX_IDLE = 2'b00;
    localparam logic [1:0] SFX_SHOT = 2'b01;
    localparam logic [1:0] SFX_HIT  = 2'b10;

    // 16-bit Fibonacci LFSR: taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Low LFSR bits added to the hit half-period floor.
    localparam int unsigned LFSR_HALF_BITS = 14;

    // One LFSR shift: new bit enters at bit 0, parity of the tapped bits.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sfx_edge_sync.sv
// Two-flop synchroniser for an asynchronous event level, followed by a
// registered rising-edge detector that emits a single-cycle pulse.
module sfx_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic pulse_o
);

    // sync_q[0..1] are the synchroniser stages, sync_q[2] the edge-detect history.
    logic [2:0] sync_q, sync_d;
    logic       pulse_q, pulse_d;

    // Shift the level through the chain and flag a 0->1 transition.
    always_comb begin
        sync_d  = {sync_q[1:0], level_i};
        pulse_d = sync_q[1] & ~sync_q[2];
    end

    // Synchroniser and pulse registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: turns shot/collision event levels into one
// square-wave effect at a time on the audio pin. Shot is a falling-pitch
// sweep (half-period grows each step); hit is an LFSR-randomised rumble.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int unsigned HALF_W          = 18,
    parameter int unsigned STEP_CYCLES     = 1000000,
    parameter int unsigned SHOT_START_HALF = 50000,
    parameter int unsigned SHOT_STEP_HALF  = 2500,
    parameter int unsigned SHOT_STEPS      = 20,
    parameter int unsigned HIT_BASE_HALF   = 100000,
    parameter int unsigned HIT_STEPS       = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shot,
    input  logic       collision,
    output logic       pin,
    output logic       busy,
    output logic [1:0] sfx_id
);

    localparam int unsigned STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned MAX_STEPS = (SHOT_STEPS > HIT_STEPS) ? SHOT_STEPS : HIT_STEPS;
    localparam int unsigned IDX_W     = $clog2(MAX_STEPS + 1);

    localparam logic [HALF_W-1:0] SHOT_START_H = HALF_W'(SHOT_START_HALF);
    localparam logic [HALF_W-1:0] SHOT_STEP_H  = HALF_W'(SHOT_STEP_HALF);
    localparam logic [HALF_W-1:0] HIT_BASE_H   = HALF_W'(HIT_BASE_HALF);
    localparam logic [STEP_W-1:0] STEP_LAST    = STEP_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  SHOT_LAST    = IDX_W'(SHOT_STEPS - 1);
    localparam logic [IDX_W-1:0]  HIT_LAST     = IDX_W'(HIT_STEPS - 1);

    // Largest half-period each effect can load, against the counter range.
    localparam longint HALF_LIMIT = (longint'(1) << HALF_W) - 1;
    localparam longint SHOT_PEAK  = longint'(SHOT_START_HALF)
                                  + longint'(SHOT_STEPS - 1) * longint'(SHOT_STEP_HALF);
    localparam longint HIT_PEAK   = longint'(HIT_BASE_HALF)
                                  + ((longint'(1) << LFSR_HALF_BITS) - 1);

    if (SHOT_PEAK > HALF_LIMIT || HIT_PEAK > HALF_LIMIT) begin : g_half_range
        $error("sfx_sequencer: a half-period exceeds the HALF_W counter range");
    end

    // Hit half-period: floor plus the low LFSR bits, zero-extended.
    function automatic logic [HALF_W-1:0] hit_half(input logic [15:0] lfsr);
        return HIT_BASE_H + HALF_W'(lfsr[LFSR_HALF_BITS-1:0]);
    endfunction

    logic shot_req, hit_req;

    sfx_edge_sync u_shot_sync (
        .clk_i   (clk),
        .rst_i   (rst),
        .level_i (shot),
        .pulse_o (shot_req)
    );

    sfx_edge_sync u_hit_sync (
        .clk_i   (clk),
        .rst_i   (rst),
        .level_i (collision),
        .pulse_o (hit_req)
    );

    sfx_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [IDX_W-1:0]  step_idx_q, step_idx_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic              pin_q, pin_d;
    logic [15:0]       lfsr_q, lfsr_d;

    logic        restart;
    logic        step_wrap;
    logic        tone_flip;
    logic [15:0] lfsr_next;

    // Boundary flags for the step and tone counters.
    always_comb begin
        step_wrap = (step_cnt_q == STEP_LAST);
        tone_flip = (half_cnt_q == (half_q - HALF_W'(1)));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: hit beats shot; a request in the current effect restarts it.
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hit_req) begin
                    state_d = StHit;
                    restart = 1'b1;
                end else if (shot_req) begin
                    state_d = StShot;
                    restart = 1'b1;
                end
            end
            StShot: begin
                if (hit_req) begin
                    state_d = StHit;
                    restart = 1'b1;
                end else if (shot_req) begin
                    state_d = StShot;
                    restart = 1'b1;
                end else if (step_wrap && step_idx_q == SHOT_LAST) begin
                    state_d = StIdle;
                end
            end
            StHit: begin
                // A shot cannot interrupt the rumble.
                if (hit_req) begin
                    state_d = StHit;
                    restart = 1'b1;
                end else if (step_wrap && step_idx_q == HIT_LAST) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state; pin comes straight from its flop.
    always_comb begin
        busy = (state_q != StIdle);
        unique case (state_q)
            StShot:  sfx_id = SFX_SHOT;
            StHit:   sfx_id = SFX_HIT;
            default: sfx_id = SFX_IDLE;
        endcase
        pin = pin_q;
    end

    // Step, tone and LFSR next-state.
    always_comb begin
        step_cnt_d = step_cnt_q;
        step_idx_d = step_idx_q;
        half_cnt_d = half_cnt_q;
        half_d     = half_q;
        pin_d      = pin_q;
        lfsr_d     = lfsr_q;
        lfsr_next  = lfsr_step(lfsr_q);

        if (restart) begin
            step_cnt_d = '0;
            step_idx_d = '0;
            half_cnt_d = '0;
            pin_d      = 1'b0;
            half_d     = (state_d == StHit) ? hit_half(lfsr_q) : SHOT_START_H;
        end else if (state_d == StIdle) begin
            step_cnt_d = '0;
            step_idx_d = '0;
            half_cnt_d = '0;
            half_d     = '0;
            pin_d      = 1'b0;
            // The final hit step still counts as a step boundary.
            if (state_q == StHit && step_wrap) begin
                lfsr_d = lfsr_next;
            end
        end else if (step_wrap) begin
            // New step: reload the half-period, pin holds its level.
            step_cnt_d = '0;
            step_idx_d = step_idx_q + IDX_W'(1);
            half_cnt_d = '0;
            if (state_q == StHit) begin
                lfsr_d = lfsr_next;
                half_d = hit_half(lfsr_next);
            end else begin
                half_d = half_q + SHOT_STEP_H;
            end
        end else begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
            if (tone_flip) begin
                half_cnt_d = '0;
                pin_d      = ~pin_q;
            end else begin
                half_cnt_d = half_cnt_q + HALF_W'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt_q <= '0;
            step_idx_q <= '0;
            half_cnt_q <= '0;
            half_q     <= '0;
            pin_q      <= 1'b0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            step_cnt_q <= step_cnt_d;
            step_idx_q <= step_idx_d;
            half_cnt_q <= half_cnt_d;
            half_q     <= half_d;
            pin_q      <= pin_d;
            lfsr_q     <= lfsr_d;
        end
    end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: directed scenarios plus randomised event traffic.
// A reference model pushes the expected {pin, busy, sfx_id} for every clock
// edge into a queue; a monitor pops and compares on the following falling edge.
module tb_sfx_sequencer;

    localparam int HALF_W     = 16;
    localparam int STEP       = 100;
    localparam int SHOT_START = 10;
    localparam int SHOT_STEP  = 2;
    localparam int SHOT_STEPS = 4;
    localparam int HIT_BASE   = 20;
    localparam int HIT_STEPS  = 3;

    logic       clk;
    logic       rst;
    logic       shot;
    logic       collision;
    logic       pin;
    logic       busy;
    logic [1:0] sfx_id;

    sfx_sequencer #(
        .HALF_W          (HALF_W),
        .STEP_CYCLES     (STEP),
        .SHOT_START_HALF (SHOT_START),
        .SHOT_STEP_HALF  (SHOT_STEP),
        .SHOT_STEPS      (SHOT_STEPS),
        .HIT_BASE_HALF   (HIT_BASE),
        .HIT_STEPS       (HIT_STEPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .shot      (shot),
        .collision (collision),
        .pin       (pin),
        .busy      (busy),
        .sfx_id    (sfx_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    // Reference model state: which effect plays, the edge it started on, and
    // the LFSR value it started with.
    int          cyc     = 0;
    int          kind    = 0;   // 0 idle, 1 shot, 2 hit
    int          ent     = 0;
    logic [15:0] lfsr_g  = 16'hACE1;
    logic [15:0] l0      = 16'hACE1;
    logic        sh_prev = 1'b0;
    logic        co_prev = 1'b0;
    int          sh_act[$];
    int          co_act[$];

    function automatic logic [15:0] lfsr_adv(input logic [15:0] x, input int n);
        logic [15:0] v;
        v = x;
        for (int i = 0; i < n; i++) begin
            v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        end
        return v;
    endfunction

    function automatic int half_of(input int j);
        if (kind == 1) return SHOT_START + j * SHOT_STEP;
        return HIT_BASE + int'(lfsr_adv(l0, j) & 16'h3FFF);
    endfunction

    // Pin level = parity of toggles so far; step j toggles at offsets k*half(j)
    // strictly inside the step (a toggle landing on the boundary is dropped).
    function automatic logic [3:0] expect_now(input int m);
        int t, s, o, tog;
        logic [1:0] code;
        if (kind == 0) return 4'b0000;
        t   = m - ent;
        s   = t / STEP;
        o   = t % STEP;
        tog = 0;
        for (int j = 0; j < s; j++) tog += (STEP - 1) / half_of(j);
        tog += o / half_of(s);
        code = (kind == 1) ? 2'b01 : 2'b10;
        return {tog[0], 1'b1, code};
    endfunction

    task automatic model_edge();
        bit hreq, sreq;
        int steps;
        cyc++;
        if (rst) begin
            kind    = 0;
            lfsr_g  = 16'hACE1;
            sh_prev = 1'b0;
            co_prev = 1'b0;
            sh_act.delete();
            co_act.delete();
            exp_q.push_back(4'b0000);
            return;
        end
        // A rise sampled at this edge changes the effect three edges later.
        if (shot && !sh_prev) sh_act.push_back(cyc + 3);
        if (collision && !co_prev) co_act.push_back(cyc + 3);
        sh_prev = shot;
        co_prev = collision;
        hreq = (co_act.size() > 0 && co_act[0] == cyc);
        sreq = (sh_act.size() > 0 && sh_act[0] == cyc);
        if (hreq) void'(co_act.pop_front());
        if (sreq) void'(sh_act.pop_front());
        steps = (kind == 1) ? SHOT_STEPS : HIT_STEPS;
        if (hreq) begin
            if (kind == 2) lfsr_g = lfsr_adv(l0, (cyc - ent - 1) / STEP);
            kind = 2;
            ent  = cyc;
            l0   = lfsr_g;
        end else if (sreq && kind != 2) begin
            kind = 1;
            ent  = cyc;
        end else if (kind != 0 && cyc - ent == steps * STEP) begin
            if (kind == 2) lfsr_g = lfsr_adv(l0, HIT_STEPS);
            kind = 0;
        end
        exp_q.push_back(expect_now(cyc));
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got pin=%b busy=%b sfx_id=%b want pin=%b busy=%b sfx_id=%b",
                     name, $time, got[3], got[2], got[1:0], want[3], want[2], want[1:0]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge();
        end
    end

    // Monitor: compare outputs against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [3:0] want;
                want = exp_q.pop_front();
                check("outputs", {pin, busy, sfx_id}, want);
            end
        end
    end

    task automatic drive(input bit s, input bit c, input int hi, input int lo);
        @(negedge clk);
        shot      = s;
        collision = c;
        repeat (hi) @(negedge clk);
        shot      = 1'b0;
        collision = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        int sh_left;
        int co_left;
        rst       = 1'b1;
        shot      = 1'b0;
        collision = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        drive(0, 0, 0, 1000);      // idle
        drive(1, 0, 5, 450);       // single shot sweep
        drive(1, 0, 2000, 100);    // held shot: one effect only
        drive(1, 0, 5, 230);       // shot ...
        drive(0, 1, 5, 400);       // ... preempted by hit during step 2
        drive(0, 1, 5, 100);       // hit ...
        drive(1, 0, 5, 300);       // ... shot ignored
        drive(1, 1, 5, 350);       // simultaneous rise: hit wins

        // Asynchronous reset in the middle of a shot.
        drive(1, 0, 5, 150);
        @(negedge clk);
        #3 rst = 1'b1;
        #1 check("async_reset", {pin, busy, sfx_id}, 4'b0000);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        drive(0, 0, 0, 200);

        // Random event traffic.
        sh_left = 0;
        co_left = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (sh_left == 0) begin
                shot    = ~shot;
                sh_left = shot ? int'($urandom_range(20, 1)) : int'($urandom_range(700, 2));
            end else begin
                sh_left--;
            end
            if (co_left == 0) begin
                collision = ~collision;
                co_left   = collision ? int'($urandom_range(20, 1)) : int'($urandom_range(1500, 2));
            end else begin
                co_left--;
            end
        end
        shot      = 1'b0;
        collision = 1'b0;
        repeat (600) @(negedge clk);

        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
